// File: rtl/bridge_pkg.sv
// Shared definitions for the UART command / SPI sampling bridge:
// FSM encoding, command byte layout and fixed byte constants.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_REQ,
        ST_SPI_WAIT,
        ST_TX_LOAD,
        ST_TX_PULSE,
        ST_TX_GAP,
        ST_TX_WAIT
    } state_t;

    localparam int CMD_MODE_BIT = 7;
    localparam int CMD_EN_BIT   = 6;
    localparam int CMD_CH_LSB   = 0;
    localparam int CMD_CH_W     = 3;

    localparam logic [7:0] HEADER_BASE = 8'hA0;
    localparam logic [7:0] SPI_TX_IDLE = 8'h00;

    function automatic int bytes_for(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/bridge_cmd_fifo.sv
// Small synchronous FIFO holding pending single-read channel indices.
// Push is ignored when full and pop is ignored when empty.
module bridge_cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/spi_uart_bridge.sv
// UART command decoder driving an SPI master: queued single reads, periodic
// polling, result field extraction and MSB-first byte packing onto the UART.
module spi_uart_bridge
    import bridge_pkg::*;
#(
    parameter int FRAME_W     = 15,
    parameter int FIELD_LSB   = 3,
    parameter int FIELD_W     = 8,
    parameter int NUM_CH      = 1,
    parameter int CMD_DEPTH   = 4,
    parameter int POLL_CYCLES = 1000000,
    parameter int HEADER      = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_arrived,
    input  logic [7:0]         i_rx_data,
    input  logic               i_tx_ready,
    output logic               o_tx_send,
    output logic [7:0]         o_tx_data,
    input  logic               i_spi_ready,
    output logic               o_spi_send,
    output logic [7:0]         o_spi_txd,
    input  logic               i_spi_arrived,
    input  logic [FRAME_W-1:0] i_spi_rxd,
    output logic [CH_W-1:0]    o_chan_sel,
    output logic               o_poll_en,
    output logic               o_busy,
    output logic               o_ovf,
    output logic               o_err
);

    localparam int NB    = bytes_for(FIELD_W);
    localparam int TOT_B = NB + HEADER;
    localparam int TOT_W = TOT_B * 8;
    localparam int CNT_W = $clog2(POLL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_CYCLES - 1);

    if (FIELD_W < 1 || FIELD_W > 16 || FIELD_LSB < 0 || FIELD_LSB + FIELD_W > FRAME_W ||
        NUM_CH < 1 || NUM_CH > 8 || CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
        POLL_CYCLES < 16 || HEADER < 0 || HEADER > 1) begin : g_bad_params
        $error("spi_uart_bridge: illegal parameter combination");
    end

    state_t             r_state;
    logic               r_spi_send;
    logic               r_tx_send;
    logic [7:0]         r_tx_data;
    logic [CH_W-1:0]    r_chan_sel;
    logic [TOT_W-1:0]   r_shift;
    logic [1:0]         r_left;
    logic               r_poll_en;
    logic [CH_W-1:0]    r_poll_ch;
    logic [CNT_W-1:0]   r_poll_cnt;
    logic               r_poll_pend;
    logic               r_ovf;
    logic               r_err;

    logic [CMD_CH_W-1:0] w_cmd_ch;
    logic               w_ch_ok;
    logic               w_is_poll;
    logic               w_push_req;
    logic               w_pop;
    logic               w_poll_take;
    logic [CH_W-1:0]    w_fifo_rdata;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [NB*8-1:0]    w_field;
    logic [TOT_W-1:0]   w_load;
    logic               w_unused;

    assign w_cmd_ch    = i_rx_data[CMD_CH_LSB +: CMD_CH_W];
    assign w_ch_ok     = int'(w_cmd_ch) < NUM_CH;
    assign w_is_poll   = i_rx_data[CMD_MODE_BIT];
    assign w_push_req  = i_rx_arrived && !w_is_poll && w_ch_ok;
    assign w_pop       = (r_state == ST_IDLE) && i_spi_ready && !w_fifo_empty;
    assign w_poll_take = (r_state == ST_IDLE) && i_spi_ready && w_fifo_empty && r_poll_pend;
    assign w_unused    = ^{i_rx_data[5:3], i_spi_rxd};

    bridge_cmd_fifo #(
        .WIDTH(CH_W),
        .DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_push_req),
        .i_wdata(w_cmd_ch[CH_W-1:0]),
        .i_pop  (w_pop),
        .o_rdata(w_fifo_rdata),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    // Header (if any) sits in the top byte so every byte leaves from the MSB end.
    always_comb begin
        w_field = '0;
        w_field[FIELD_W-1:0] = i_spi_rxd[FIELD_LSB +: FIELD_W];
        w_load = '0;
        w_load[NB*8-1:0] = w_field;
        if (HEADER != 0) w_load[TOT_W-1 -: 8] = HEADER_BASE | 8'(r_chan_sel);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_poll_en   <= 1'b0;
            r_poll_ch   <= '0;
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= i_rx_arrived && !w_ch_ok;
            if (w_push_req && w_fifo_full) r_ovf <= 1'b1;
            if (w_poll_take) r_poll_pend <= 1'b0;
            if (r_poll_en) begin
                if (r_poll_cnt == CNT_LAST) begin
                    r_poll_cnt  <= '0;
                    r_poll_pend <= 1'b1;
                end else begin
                    r_poll_cnt <= r_poll_cnt + 1'b1;
                end
            end
            if (i_rx_arrived && w_is_poll && w_ch_ok) begin
                if (i_rx_data[CMD_EN_BIT]) begin
                    r_poll_en  <= 1'b1;
                    r_poll_ch  <= w_cmd_ch[CH_W-1:0];
                    r_poll_cnt <= '0;
                end else begin
                    r_poll_en   <= 1'b0;
                    r_poll_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_spi_send <= 1'b0;
            r_tx_send  <= 1'b0;
            r_tx_data  <= '0;
            r_chan_sel <= '0;
            r_shift    <= '0;
            r_left     <= '0;
        end else begin
            r_spi_send <= 1'b0;
            r_tx_send  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_chan_sel <= w_fifo_rdata;
                        r_spi_send <= 1'b1;
                        r_state    <= ST_SPI_REQ;
                    end else if (w_poll_take) begin
                        r_chan_sel <= r_poll_ch;
                        r_spi_send <= 1'b1;
                        r_state    <= ST_SPI_REQ;
                    end
                end
                ST_SPI_REQ: r_state <= ST_SPI_WAIT;
                ST_SPI_WAIT: begin
                    if (i_spi_arrived) begin
                        r_shift <= w_load;
                        r_left  <= 2'(TOT_B - 1);
                        r_state <= ST_TX_LOAD;
                    end
                end
                ST_TX_LOAD: begin
                    if (i_tx_ready) begin
                        r_tx_data <= r_shift[TOT_W-1 -: 8];
                        r_shift   <= r_shift << 8;
                        r_tx_send <= 1'b1;
                        r_state   <= ST_TX_PULSE;
                    end
                end
                ST_TX_PULSE: r_state <= ST_TX_GAP;
                ST_TX_GAP:   r_state <= ST_TX_WAIT;
                ST_TX_WAIT: begin
                    if (i_tx_ready) begin
                        if (r_left != 2'd0) begin
                            r_left  <= r_left - 2'd1;
                            r_state <= ST_TX_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_send  = r_tx_send;
    assign o_tx_data  = r_tx_data;
    assign o_spi_send = r_spi_send;
    assign o_spi_txd  = SPI_TX_IDLE;
    assign o_chan_sel = r_chan_sel;
    assign o_poll_en  = r_poll_en;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_ovf      = r_ovf;
    assign o_err      = r_err;

endmodule

// File: tb/tb_spi_uart_bridge.sv
// Bench for spi_uart_bridge: a default-parameter instance and a 4-channel
// header/12-bit-field/fast-poll instance with SPI and UART endpoint models.
module tb_spi_uart_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // default-parameter instance
    logic        a_rst = 1'b1;
    logic        a_rx_arrived = 1'b0;
    logic [7:0]  a_rx_data = '0;
    logic        a_tx_ready = 1'b1;
    logic        a_tx_send;
    logic [7:0]  a_tx_data;
    logic        a_spi_ready = 1'b1;
    logic        a_spi_send;
    logic [7:0]  a_spi_txd;
    logic        a_spi_arrived = 1'b0;
    logic [14:0] a_spi_rxd = '0;
    logic [0:0]  a_chan_sel;
    logic        a_poll_en, a_busy, a_ovf, a_err;

    // 4-channel header instance
    logic        b_rst = 1'b1;
    logic        b_rx_arrived = 1'b0;
    logic [7:0]  b_rx_data = '0;
    logic        b_tx_ready = 1'b1;
    logic        b_tx_send;
    logic [7:0]  b_tx_data;
    logic        b_spi_ready = 1'b1;
    logic        b_spi_send;
    logic [7:0]  b_spi_txd;
    logic        b_spi_arrived = 1'b0;
    logic [14:0] b_spi_rxd = '0;
    logic [1:0]  b_chan_sel;
    logic        b_poll_en, b_busy, b_ovf, b_err;

    logic [14:0] b_frame = 15'h0ABC;
    logic        b_spi_stall = 1'b0;
    int          b_spi_cnt = 0;
    int          b_tx_cnt = 0;
    int          b_spi_times[$];
    logic [1:0]  exp_ch[$];
    logic [7:0]  exp_tx[$];

    spi_uart_bridge u_dut_a (
        .i_clk(clk), .i_rst(a_rst),
        .i_rx_arrived(a_rx_arrived), .i_rx_data(a_rx_data),
        .i_tx_ready(a_tx_ready), .o_tx_send(a_tx_send), .o_tx_data(a_tx_data),
        .i_spi_ready(a_spi_ready), .o_spi_send(a_spi_send), .o_spi_txd(a_spi_txd),
        .i_spi_arrived(a_spi_arrived), .i_spi_rxd(a_spi_rxd),
        .o_chan_sel(a_chan_sel), .o_poll_en(a_poll_en), .o_busy(a_busy),
        .o_ovf(a_ovf), .o_err(a_err)
    );

    spi_uart_bridge #(
        .FRAME_W(15), .FIELD_LSB(0), .FIELD_W(12), .NUM_CH(4),
        .CMD_DEPTH(4), .POLL_CYCLES(100), .HEADER(1)
    ) u_dut_b (
        .i_clk(clk), .i_rst(b_rst),
        .i_rx_arrived(b_rx_arrived), .i_rx_data(b_rx_data),
        .i_tx_ready(b_tx_ready), .o_tx_send(b_tx_send), .o_tx_data(b_tx_data),
        .i_spi_ready(b_spi_ready), .o_spi_send(b_spi_send), .o_spi_txd(b_spi_txd),
        .i_spi_arrived(b_spi_arrived), .i_spi_rxd(b_spi_rxd),
        .o_chan_sel(b_chan_sel), .o_poll_en(b_poll_en), .o_busy(b_busy),
        .o_ovf(b_ovf), .o_err(b_err)
    );

    initial forever @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // SPI endpoint for instance B: checks chan_sel against the expected queue.
    initial begin : b_spi_model
        logic [1:0] ch;
        forever begin
            @(negedge clk);
            if (b_spi_send === 1'b1) begin
                b_spi_cnt++;
                b_spi_times.push_back(cyc);
                b_spi_ready = 1'b0;
                checks++;
                if (exp_ch.size() == 0) begin
                    errors++;
                    $display("FAIL b_spi_unexpected: chan_sel=%0d, required no transfer", b_chan_sel);
                    ch = b_chan_sel;
                end else begin
                    ch = exp_ch.pop_front();
                    if (b_chan_sel !== ch) begin
                        errors++;
                        $display("FAIL b_chan_sel: got %0d, required %0d", b_chan_sel, ch);
                    end
                end
                if (!b_spi_stall) begin
                    repeat (3) @(negedge clk);
                    checks++;
                    if (b_chan_sel !== ch) begin
                        errors++;
                        $display("FAIL b_chan_stable: got %0d, required %0d", b_chan_sel, ch);
                    end
                    b_spi_rxd = b_frame;
                    b_spi_arrived = 1'b1;
                    @(negedge clk);
                    b_spi_arrived = 1'b0;
                    b_spi_ready = 1'b1;
                end
            end
        end
    end

    // UART writer for instance B: pops expected bytes in order.
    initial begin : b_tx_model
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (b_tx_send === 1'b1) begin
                b_tx_cnt++;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL b_tx_unexpected: tx_data=%02h, required no byte", b_tx_data);
                end else begin
                    exp_b = exp_tx.pop_front();
                    if (b_tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL b_tx_data: got %02h, required %02h", b_tx_data, exp_b);
                    end
                end
                b_tx_ready = 1'b0;
                repeat (3) @(negedge clk);
                b_tx_ready = 1'b1;
            end
        end
    end

    task automatic send_a(input logic [7:0] cmd);
        a_rx_data = cmd;
        a_rx_arrived = 1'b1;
        @(negedge clk);
        a_rx_arrived = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] cmd);
        b_rx_data = cmd;
        b_rx_arrived = 1'b1;
        @(negedge clk);
        b_rx_arrived = 1'b0;
    endtask

    task automatic push_b_resp(input logic [1:0] ch, input logic [14:0] frame);
        exp_ch.push_back(ch);
        exp_tx.push_back(8'hA0 | {6'b0, ch});
        exp_tx.push_back({4'h0, frame[11:8]});
        exp_tx.push_back(frame[7:0]);
    endtask

    task automatic wait_b_spi(input int target, input int limit);
        int n = 0;
        while (b_spi_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_b_tx(input int target, input int limit);
        int n = 0;
        while (b_tx_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_tx_send, a_tx_data, a_spi_send, a_spi_txd, a_chan_sel, a_poll_en, a_busy, a_ovf, a_err} !== '0) begin
            errors++;
            $display("FAIL reset_a_outputs: got tx_data=%02h busy=%b, required all zero", a_tx_data, a_busy);
        end
        checks++;
        if ({b_tx_send, b_tx_data, b_spi_send, b_spi_txd, b_chan_sel, b_poll_en, b_busy, b_ovf, b_err} !== '0) begin
            errors++;
            $display("FAIL reset_b_outputs: got tx_data=%02h busy=%b, required all zero", b_tx_data, b_busy);
        end
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_busy, a_spi_send, a_tx_send, b_busy, b_spi_send, b_tx_send} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b, required 000000",
                     {a_busy, a_spi_send, a_tx_send, b_busy, b_spi_send, b_tx_send});
        end
    endtask

    task automatic test_default;
        int n;
        int rel;
        int txn;
        logic [7:0] got;
        send_a(8'h00);
        n = 1;
        while (a_spi_send !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL default_latency: got %0d cycles, required 2", n);
        end
        checks++;
        if (a_chan_sel !== 1'b0) begin
            errors++;
            $display("FAIL default_chan: got %0d, required 0", a_chan_sel);
        end
        a_spi_ready = 1'b0;
        repeat (3) @(negedge clk);
        a_spi_rxd = 15'h2A5C;
        a_spi_arrived = 1'b1;
        @(negedge clk);
        a_spi_arrived = 1'b0;
        a_spi_ready = 1'b1;
        txn = 0;
        rel = 0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_tx_send === 1'b1) begin
                txn++;
                got = a_tx_data;
                a_tx_ready = 1'b0;
                rel = 3;
            end else if (rel > 0) begin
                rel--;
                if (rel == 0) a_tx_ready = 1'b1;
            end
        end
        checks++;
        if (txn !== 1) begin
            errors++;
            $display("FAIL default_tx_count: got %0d, required 1", txn);
        end
        checks++;
        if (got !== 8'h4B) begin
            errors++;
            $display("FAIL default_tx_data: got %02h, required 4b", got);
        end
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL default_idle: busy got %b, required 0", a_busy);
        end
    endtask

    task automatic test_header;
        int t0 = b_tx_cnt;
        b_frame = 15'h0ABC;
        push_b_resp(2'd2, b_frame);
        send_b(8'h02);
        wait_b_tx(t0 + 3, 200);
        checks++;
        if (b_tx_cnt !== t0 + 3) begin
            errors++;
            $display("FAIL header_tx_count: got %0d, required %0d", b_tx_cnt - t0, 3);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (b_busy !== 1'b0) begin
            errors++;
            $display("FAIL header_idle: busy got %b, required 0", b_busy);
        end
    endtask

    task automatic test_err;
        int s0 = b_spi_cnt;
        send_a(8'h01);
        checks++;
        if (a_err !== 1'b1) begin
            errors++;
            $display("FAIL err_a_pulse: got %b, required 1", a_err);
        end
        send_b(8'h05);
        checks++;
        if (b_err !== 1'b1) begin
            errors++;
            $display("FAIL err_b_pulse: got %b, required 1", b_err);
        end
        @(negedge clk);
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL err_b_single: got %b, required 0", b_err);
        end
        send_b(8'hC7);
        checks++;
        if ({b_err, b_poll_en} !== 2'b10) begin
            errors++;
            $display("FAIL err_b_poll_cmd: err,poll_en got %b, required 10", {b_err, b_poll_en});
        end
        repeat (20) @(negedge clk);
        checks++;
        if (b_spi_cnt !== s0 || b_busy !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL err_no_transfer: got %0d transfers, required 0", b_spi_cnt - s0);
        end
    endtask

    task automatic test_overflow;
        int s0 = b_spi_cnt;
        int t0 = b_tx_cnt;
        b_spi_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_b_resp(2'(i), b_frame);
        for (int i = 0; i < 6; i++) begin
            b_rx_data = 8'(i % 4);
            b_rx_arrived = 1'b1;
            @(negedge clk);
        end
        b_rx_arrived = 1'b0;
        checks++;
        if (b_ovf !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: ovf,busy got %b, required 10", {b_ovf, b_busy});
        end
        b_spi_ready = 1'b1;
        wait_b_tx(t0 + 12, 600);
        repeat (20) @(negedge clk);
        checks++;
        if (b_spi_cnt !== s0 + 4) begin
            errors++;
            $display("FAIL ovf_transfers: got %0d, required 4", b_spi_cnt - s0);
        end
        checks++;
        if (b_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 1", b_ovf);
        end
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (b_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reset: got %b, required 0", b_ovf);
        end
    endtask

    task automatic test_poll;
        int s0 = b_spi_cnt;
        int t0 = b_tx_cnt;
        int st = b_spi_times.size();
        for (int i = 0; i < 3; i++) push_b_resp(2'd1, b_frame);
        send_b(8'hC1);
        checks++;
        if (b_poll_en !== 1'b1) begin
            errors++;
            $display("FAIL poll_enable: got %b, required 1", b_poll_en);
        end
        repeat (349) @(negedge clk);
        send_b(8'h80);
        checks++;
        if (b_poll_en !== 1'b0) begin
            errors++;
            $display("FAIL poll_disable: got %b, required 0", b_poll_en);
        end
        repeat (150) @(negedge clk);
        checks++;
        if (b_spi_cnt !== s0 + 3 || b_tx_cnt !== t0 + 9) begin
            errors++;
            $display("FAIL poll_count: got %0d transfers %0d bytes, required 3 and 9",
                     b_spi_cnt - s0, b_tx_cnt - t0);
        end
        for (int k = 1; k < 3; k++) begin
            if (b_spi_times.size() > st + k) begin
                checks++;
                if (b_spi_times[st + k] - b_spi_times[st + k - 1] !== 100) begin
                    errors++;
                    $display("FAIL poll_spacing: got %0d cycles, required 100",
                             b_spi_times[st + k] - b_spi_times[st + k - 1]);
                end
            end
        end
    endtask

    task automatic test_priority;
        int s0 = b_spi_cnt;
        int t0 = b_tx_cnt;
        b_frame = 15'h7E5A;
        b_spi_ready = 1'b0;
        send_b(8'hC3);
        repeat (110) @(negedge clk);
        send_b(8'h02);
        push_b_resp(2'd2, b_frame);
        push_b_resp(2'd3, b_frame);
        @(negedge clk);
        b_spi_ready = 1'b1;
        wait_b_spi(s0 + 2, 150);
        send_b(8'h80);
        checks++;
        if (b_spi_cnt !== s0 + 2) begin
            errors++;
            $display("FAIL prio_transfers: got %0d, required 2", b_spi_cnt - s0);
        end
        wait_b_tx(t0 + 6, 200);
        repeat (150) @(negedge clk);
        checks++;
        if (b_tx_cnt !== t0 + 6 || b_spi_cnt !== s0 + 2) begin
            errors++;
            $display("FAIL prio_bytes: got %0d bytes %0d transfers, required 6 and 2",
                     b_tx_cnt - t0, b_spi_cnt - s0);
        end
    endtask

    task automatic test_reset_midflight;
        int s0 = b_spi_cnt;
        int t0 = b_tx_cnt;
        b_spi_stall = 1'b1;
        exp_ch.push_back(2'd0);
        send_b(8'h00);
        wait_b_spi(s0 + 1, 20);
        checks++;
        if (b_spi_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL midflight_start: got %0d transfers, required 1", b_spi_cnt - s0);
        end
        @(posedge clk);
        #2;
        checks++;
        if (b_busy !== 1'b1) begin
            errors++;
            $display("FAIL midflight_busy: got %b, required 1", b_busy);
        end
        b_rst = 1'b1;
        #1;
        checks++;
        if ({b_tx_send, b_tx_data, b_spi_send, b_spi_txd, b_chan_sel, b_poll_en, b_busy, b_ovf, b_err} !== '0) begin
            errors++;
            $display("FAIL midflight_async_reset: busy got %b tx_data %02h, required all zero", b_busy, b_tx_data);
        end
        @(negedge clk);
        b_rst = 1'b0;
        b_spi_stall = 1'b0;
        b_spi_ready = 1'b1;
        b_spi_rxd = b_frame;
        b_spi_arrived = 1'b1;
        @(negedge clk);
        b_spi_arrived = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (b_tx_cnt !== t0 || b_spi_cnt !== s0 + 1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL midflight_quiet: got %0d bytes busy %b, required 0 and 0", b_tx_cnt - t0, b_busy);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_header();
        test_err();
        test_overflow();
        test_poll();
        test_priority();
        test_reset_midflight();
        checks++;
        if (exp_ch.size() !== 0 || exp_tx.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d channels %0d bytes left, required 0",
                     exp_ch.size(), exp_tx.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
